paddle_engine: RTL and testbench

PADDLE_ENGINE -- requirements
Module: paddle_engine

---
 rtl/paddle_engine.sv | 170 +++++++++++++++++
 tb/tb_paddle_engine.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_engine.sv
// Breakout-style paddle: frame-rate movement, stepped resize FSM and pixel/zone generation.
// Optional blink feature enabled by defining PADDLE_BLINK_EN (adds flash input and frame counter).
module paddle_engine #(
  parameter logic [5:0]  PADDLE_COLOR  = 6'b111111,
  parameter int unsigned PADDLE_HEIGHT = 8,
  parameter int unsigned PADDLE_Y      = 456,
  parameter int unsigned MIN_WIDTH     = 32,
  parameter int unsigned MAX_WIDTH     = 127,
  parameter int unsigned DEF_WIDTH     = 99,
  parameter int unsigned SPEED         = 4,
  parameter int unsigned SCREEN_W      = 640
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [9:0] hpos,
  input  logic [8:0] vpos,
  input  logic       frame_start,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       width_req,
  input  logic [6:0] target_width,
`ifdef PADDLE_BLINK_EN
  input  logic       flash,
`endif
  output logic       in_paddle,
  output logic [5:0] color,
  output logic [1:0] zone,
  output logic [9:0] paddle_x,
  output logic [6:0] paddle_w
);

  localparam logic [8:0]  LP_Y     = 9'(PADDLE_Y);
  localparam logic [8:0]  LP_Y_END = 9'(PADDLE_Y + PADDLE_HEIGHT);
  localparam logic [6:0]  LP_MINW  = 7'(MIN_WIDTH);
  localparam logic [6:0]  LP_MAXW  = 7'(MAX_WIDTH);
  localparam logic [6:0]  LP_DEFW  = 7'(DEF_WIDTH);
  localparam logic [9:0]  LP_DEFX  = 10'((SCREEN_W - DEF_WIDTH) >> 1);
  localparam logic [10:0] LP_SW    = 11'(SCREEN_W);
  localparam logic [10:0] LP_SPEED = 11'(SPEED);

  typedef enum logic [1:0] {IDLE, GROW, SHRINK} state_t;

  state_t      r_state, w_state_nxt;
  logic [9:0]  r_x, w_x_nxt;
  logic [6:0]  r_w, w_w_nxt, r_target, r_q, r_hcnt;
  logic        r_hspan, r_vspan;
  logic [6:0]  w_grow_w, w_shrink_w, w_tgt;
  logic [7:0]  w_up, w_c8, w_q8;
  logic [10:0] w_x_move, w_x_lim;
  logic [1:0]  w_zone;
  logic        w_blank;

  assign w_tgt = (target_width < LP_MINW) ? LP_MINW :
                 (target_width > LP_MAXW) ? LP_MAXW : target_width;

  always_comb begin
    w_state_nxt = r_state;
    w_w_nxt     = r_w;
    w_x_nxt     = r_x;
    w_x_move    = {1'b0, r_x};
    w_x_lim     = '0;
    w_up        = {1'b0, r_w} + 8'd2;
    w_grow_w    = (w_up > {1'b0, r_target}) ? r_target : w_up[6:0];
    w_shrink_w  = (({1'b0, r_target} + 8'd2) > {1'b0, r_w}) ? r_target : r_w - 7'd2;
    if (frame_start) begin
      case (r_state)
        IDLE: begin
          if (r_target > r_w) begin
            w_state_nxt = GROW;
            w_w_nxt     = w_grow_w;
          end else if (r_target < r_w) begin
            w_state_nxt = SHRINK;
            w_w_nxt     = w_shrink_w;
          end
        end
        GROW: begin
          if (r_target < r_w) begin
            w_state_nxt = SHRINK;
            w_w_nxt     = w_shrink_w;
          end else begin
            w_w_nxt = w_grow_w;
          end
        end
        SHRINK: begin
          if (r_target > r_w) begin
            w_state_nxt = GROW;
            w_w_nxt     = w_grow_w;
          end else begin
            w_w_nxt = w_shrink_w;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
      if (w_w_nxt == r_target) w_state_nxt = IDLE;

      case ({move_left, move_right})
        2'b10:   w_x_move = ({1'b0, r_x} >= LP_SPEED) ? {1'b0, r_x} - LP_SPEED : '0;
        2'b01:   w_x_move = {1'b0, r_x} + LP_SPEED;
        default: w_x_move = {1'b0, r_x};
      endcase
      // Clamp against the width being written this frame so x+w never exceeds the screen
      w_x_lim = LP_SW - {4'b0, w_w_nxt};
      w_x_nxt = (w_x_move > w_x_lim) ? w_x_lim[9:0] : w_x_move[9:0];
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state  <= IDLE;
      r_x      <= LP_DEFX;
      r_w      <= LP_DEFW;
      r_q      <= LP_DEFW >> 2;
      r_target <= LP_DEFW;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_w     <= w_w_nxt;
      if (frame_start) r_q <= w_w_nxt >> 2;
      if (width_req) r_target <= w_tgt;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_hspan <= 1'b0;
      r_hcnt  <= '0;
      r_vspan <= 1'b0;
    end else begin
      if (r_hspan) begin
        if (r_hcnt == r_w - 7'd1) begin
          r_hspan <= 1'b0;
          r_hcnt  <= '0;
        end else begin
          r_hcnt <= r_hcnt + 7'd1;
        end
      end else if (hpos == r_x) begin
        r_hspan <= 1'b1;
      end
      if (vpos == LP_Y) r_vspan <= 1'b1;
      else if (vpos == LP_Y_END) r_vspan <= 1'b0;
    end
  end

`ifdef PADDLE_BLINK_EN
  logic [3:0] r_fcnt;
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) r_fcnt <= '0;
    else if (frame_start) r_fcnt <= r_fcnt + 4'd1;
  end
  assign w_blank = flash & r_fcnt[3];
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    w_c8 = {1'b0, r_hcnt};
    w_q8 = {1'b0, r_q};
    if (w_c8 < w_q8)                      w_zone = 2'd0;
    else if (w_c8 < (w_q8 << 1))          w_zone = 2'd1;
    else if (w_c8 < w_q8 + (w_q8 << 1))   w_zone = 2'd2;
    else                                  w_zone = 2'd3;
  end

  assign in_paddle = r_hspan & r_vspan & ~w_blank;
  assign zone      = in_paddle ? w_zone : 2'd0;
  assign color     = PADDLE_COLOR;
  assign paddle_x  = r_x;
  assign paddle_w  = r_w;

endmodule

// File: tb/tb_paddle_engine.sv
// Scoreboard bench for paddle_engine: stimulus queues expected x/w and pixels, a monitor pops and compares.
module tb_paddle_engine;
  logic       clk = 1'b0;
  logic       nRst;
  logic [9:0] hpos;
  logic [8:0] vpos;
  logic       frame_start, move_left, move_right, width_req;
  logic [6:0] target_width;
  logic       in_paddle;
  logic [5:0] color;
  logic [1:0] zone;
  logic [9:0] paddle_x;
  logic [6:0] paddle_w;
`ifdef PADDLE_BLINK_EN
  logic       flash;
`endif

  always #5 clk = ~clk;

  paddle_engine dut (
    .clk(clk), .nRst(nRst), .hpos(hpos), .vpos(vpos), .frame_start(frame_start),
    .move_left(move_left), .move_right(move_right), .width_req(width_req),
    .target_width(target_width),
`ifdef PADDLE_BLINK_EN
    .flash(flash),
`endif
    .in_paddle(in_paddle), .color(color), .zone(zone),
    .paddle_x(paddle_x), .paddle_w(paddle_w)
  );

  typedef struct packed {logic [7:0] id; logic [9:0] x; logic [6:0] w;} xw_t;
  typedef struct packed {logic [9:0] col; logic [1:0] zone;} pix_t;

  int   checks = 0;
  int   errors = 0;
  int   fcnt   = 0;
  xw_t  xq[$];
  pix_t pq[$];
  xw_t  me;
  pix_t mp;
  logic chk_req = 1'b0;
  logic [9:0] samp_h;

  always @(posedge clk) samp_h <= hpos;

  always @(negedge clk) begin
    if (chk_req) begin
      checks++;
      if (xq.size() == 0) begin
        errors++;
        $display("FAIL xw_queue empty at check request");
      end else begin
        me = xq.pop_front();
        if (paddle_x !== me.x) begin
          errors++;
          $display("FAIL xw#%0d paddle_x=%0d want %0d", me.id, paddle_x, me.x);
        end
        checks++;
        if (paddle_w !== me.w) begin
          errors++;
          $display("FAIL xw#%0d paddle_w=%0d want %0d", me.id, paddle_w, me.w);
        end
        checks++;
        if (in_paddle !== 1'b0 || zone !== 2'd0 || color !== 6'b111111) begin
          errors++;
          $display("FAIL idle#%0d in_paddle=%b zone=%0d color=%b want 0 0 111111",
                   me.id, in_paddle, zone, color);
        end
      end
    end
    if (in_paddle === 1'b1) begin
      checks++;
      if (pq.size() == 0) begin
        errors++;
        $display("FAIL pix unexpected at col %0d vpos %0d", samp_h, vpos);
      end else begin
        mp = pq.pop_front();
        if (samp_h !== mp.col || zone !== mp.zone) begin
          errors++;
          $display("FAIL pix col=%0d zone=%0d want col=%0d zone=%0d", samp_h, zone, mp.col, mp.zone);
        end
      end
    end
  end

  function automatic logic [1:0] zone_of(input int c, input int w);
    int q;
    q = w / 4;
    if (c < q)          return 2'd0;
    else if (c < 2 * q) return 2'd1;
    else if (c < 3 * q) return 2'd2;
    else                return 2'd3;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic l, input logic r);
    frame_start = 1'b1; move_left = l; move_right = r;
    tick;
    frame_start = 1'b0; move_left = 1'b0; move_right = 1'b0;
    fcnt++;
    tick;
  endtask

  task automatic expect_xw(input int id, input int x, input int w);
    xw_t e;
    e.id = 8'(id); e.x = 10'(x); e.w = 7'(w);
    xq.push_back(e);
    chk_req = 1'b1;
    tick;
    chk_req = 1'b0;
  endtask

  task automatic req_width(input int t);
    width_req = 1'b1; target_width = 7'(t);
    tick;
    width_req = 1'b0;
  endtask

  task automatic push_pixels(input int x, input int w, input int n);
    pix_t p;
    for (int c = 0; c < n; c++) begin
      p.col = 10'(x + c); p.zone = zone_of(c, w);
      pq.push_back(p);
    end
  endtask

  task automatic scan(input int v);
    vpos = 9'(v);
    for (int h = 0; h < 640; h++) begin
      hpos = 10'(h);
      tick;
    end
    hpos = 10'd1023;
    tick;
    tick;
  endtask

  task automatic pix_done(input int id);
    checks++;
    if (pq.size() != 0) begin
      errors++;
      $display("FAIL pix#%0d missing=%0d want 0", id, pq.size());
      pq.delete();
    end
  endtask

  task automatic show(input int id, input int x, input int w, input bit vis);
    if (vis) push_pixels(x, w, w);
    scan(456);
    pix_done(id);
    scan(464);
    vpos = 9'd0;
  endtask

  initial begin
    int ew, ex;
    nRst = 1'b0; hpos = 10'd1023; vpos = 9'd0;
    frame_start = 1'b0; move_left = 1'b0; move_right = 1'b0;
    width_req = 1'b0; target_width = '0;
`ifdef PADDLE_BLINK_EN
    flash = 1'b0;
`endif
    tick; tick;
    expect_xw(1, 270, 99);
    nRst = 1'b1;
    tick;

    // first visible line, last visible line, and the lines either side
    scan(455);
    push_pixels(270, 99, 99);
    scan(456);
    pix_done(2);
    push_pixels(270, 99, 99);
    scan(463);
    pix_done(3);
    scan(464);
    vpos = 9'd0;

    for (int i = 0; i < 67; i++) frame(1'b1, 1'b0);
    expect_xw(4, 2, 99);
    frame(1'b1, 1'b0);
    expect_xw(5, 0, 99);
    frame(1'b1, 1'b0);
    expect_xw(6, 0, 99);
    for (int i = 0; i < 135; i++) frame(1'b0, 1'b1);
    expect_xw(7, 540, 99);
    frame(1'b0, 1'b1);
    expect_xw(8, 541, 99);
    frame(1'b0, 1'b1);
    expect_xw(9, 541, 99);
    frame(1'b1, 1'b1);
    expect_xw(10, 541, 99);
    show(11, 541, 99, 1'b1);

    req_width(10);
    for (int i = 0; i < 33; i++) frame(1'b0, 1'b0);
    expect_xw(12, 541, 33);
    frame(1'b0, 1'b0);
    expect_xw(13, 541, 32);
    frame(1'b0, 1'b0);
    expect_xw(14, 541, 32);
    show(15, 541, 32, 1'b1);

    req_width(127);
    for (int k = 1; k <= 48; k++) begin
      frame(1'b0, 1'b0);
      ew = (32 + 2 * k > 127) ? 127 : 32 + 2 * k;
      ex = (640 - ew < 541) ? 640 - ew : 541;
      expect_xw(20 + k, ex, ew);
    end
    expect_xw(70, 513, 127);
    show(71, 513, 127, 1'b1);
    frame(1'b0, 1'b1);
    expect_xw(72, 513, 127);

    @(posedge clk); #3;
    nRst = 1'b0;
    tick;
    expect_xw(73, 270, 99);
    nRst = 1'b1; fcnt = 0;
    tick;

    req_width(120);
    frame(1'b0, 1'b0);
    expect_xw(74, 270, 101);
    frame(1'b0, 1'b0);
    expect_xw(75, 270, 103);
    req_width(90);
    frame(1'b0, 1'b0);
    expect_xw(76, 270, 101);
    frame(1'b0, 1'b0);
    expect_xw(77, 270, 99);

    // grow again, then reset in the middle of a visible span
    req_width(120);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    expect_xw(78, 270, 103);
    push_pixels(270, 103, 30);
    vpos = 9'd456;
    for (int h = 0; h < 300; h++) begin
      hpos = 10'(h);
      tick;
    end
    #6;
    nRst = 1'b0;
    tick;
    expect_xw(79, 270, 99);
    pix_done(80);
    vpos = 9'd0; hpos = 10'd1023;
    nRst = 1'b1; fcnt = 0;
    tick;
    frame(1'b1, 1'b0);
    expect_xw(81, 266, 99);

`ifdef PADDLE_BLINK_EN
    flash = 1'b1;
    for (int i = 0; i < 16; i++) begin
      frame(1'b0, 1'b0);
      show(100 + i, 266, 99, (fcnt % 16) < 8);
    end
    flash = 1'b0;
`else
    for (int i = 0; i < 3; i++) begin
      frame(1'b0, 1'b0);
      show(100 + i, 266, 99, 1'b1);
    end
`endif

    checks++;
    if (xq.size() != 0) begin
      errors++;
      $display("FAIL xw_leftover=%0d want 0", xq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
